// File: rtl/video_timing_regen.sv
// video_timing_regen: output-side raster regenerator for the scaler path.
// Consumes the scaled pixel stream (valid/ready) and produces hs/vs/de/rgb
// with the scaled image placed in a programmable window inside the active
// area. Window coordinates and enable are shadowed at the frame origin.
// A starved window pixel sets a sticky underflow flag and flushes the rest
// of the frame, so the next frame starts cleanly on frame_start.
// Optional build macro: VTR_PATTERN_EN adds pattern_sel, which replaces the
// window contents with 8 vertical colour bars and stops pulling pixels.
`timescale 1ns/1ps
module video_timing_regen #(
  parameter int H_SYNC     = 44,
  parameter int H_BACK     = 148,
  parameter int H_DISP     = 1920,
  parameter int H_FRONT    = 88,
  parameter int V_SYNC     = 5,
  parameter int V_BACK     = 36,
  parameter int V_DISP     = 1080,
  parameter int V_FRONT    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 3,
  parameter int RES_WIDTH  = 11,
  parameter logic [DATA_WIDTH*CHANNELS-1:0] BORDER_RGB = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic [RES_WIDTH-1:0]           win_x,
  input  logic [RES_WIDTH-1:0]           win_y,
  input  logic [RES_WIDTH-1:0]           win_w,
  input  logic [RES_WIDTH-1:0]           win_h,
  input  logic [DATA_WIDTH*CHANNELS-1:0] din,
  input  logic                           din_valid,
`ifdef VTR_PATTERN_EN
  input  logic                           pattern_sel,
`endif
  output logic                           din_ready,
  output logic                           frame_start,
  output logic                           hs_o,
  output logic                           vs_o,
  output logic                           de_o,
  output logic [DATA_WIDTH*CHANNELS-1:0] rgb_o,
  output logic                           underflow_o
);

  localparam int PW      = DATA_WIDTH * CHANNELS;
  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int HA      = H_SYNC + H_BACK;   // first active column
  localparam int VA      = V_SYNC + V_BACK;   // first active line
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t               state, state_nx;
  logic [HW-1:0]        h_cnt;
  logic [VW-1:0]        v_cnt;
  logic [RES_WIDTH-1:0] wx_sh, wy_sh, ww_sh, wh_sh;

  int      ax, ay;
  logic    origin, live, hs_c, vs_c, de_c, in_win;
  logic    take, starve, pat;
  logic [PW-1:0] pix_c, bar_rgb;

`ifdef VTR_PATTERN_EN
  int       bar_w, off;
  logic [2:0] bar;
  assign pat = pattern_sel;

  // Colour-bar index from the pixel offset inside the window; the leftover
  // columns when the width is not a multiple of 8 stay on the last bar.
  always_comb begin
    bar_w = (int'(ww_sh) + 1) >> 3;
    off   = ax - int'(wx_sh);
    bar   = '0;
    for (int i = 1; i < 8; i++)
      if (off >= bar_w * i) bar = 3'(i);
    bar_rgb = PW'({{DATA_WIDTH{bar[2]}}, {DATA_WIDTH{bar[1]}}, {DATA_WIDTH{bar[0]}}});
  end
`else
  assign pat     = 1'b0;
  assign bar_rgb = '0;
`endif

  // Raster decode: syncs, active area and window membership from the counters.
  // Window bounds use full-width int math so wx+ww never wraps; the active
  // area test clips the window at the display edge.
  always_comb begin
    ax     = int'(h_cnt) - HA;
    ay     = int'(v_cnt) - VA;
    origin = (h_cnt == '0) && (v_cnt == '0);
    // a frame origin with enable low ends the run without drawing that cycle
    live   = (state != IDLE) && !(origin && !enable);
    hs_c   = int'(h_cnt) < H_SYNC;
    vs_c   = int'(v_cnt) < V_SYNC;
    de_c   = (ax >= 0) && (ax < H_DISP) && (ay >= 0) && (ay < V_DISP);
    in_win = de_c &&
             (ax >= int'(wx_sh)) && (ax <= int'(wx_sh) + int'(ww_sh)) &&
             (ay >= int'(wy_sh)) && (ay <= int'(wy_sh) + int'(wh_sh));
  end

  // FSM next state, handshake and pixel selection.
  always_comb begin
    state_nx  = state;
    din_ready = 1'b0;
    take      = 1'b0;
    starve    = 1'b0;
    case (state)
      IDLE: if (enable) state_nx = RUN;
      RUN: begin
        din_ready = in_win && !pat;
        if (origin && !enable)
          state_nx = IDLE;
        else if (in_win && !pat && !din_valid) begin
          starve   = 1'b1;
          state_nx = FLUSH;
        end else
          take = in_win && !pat;
      end
      FLUSH: begin
        // drain whatever upstream still holds for this frame
        din_ready = !pat;
        if (origin) state_nx = enable ? RUN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
    pix_c = BORDER_RGB;
    if (pat && in_win) pix_c = bar_rgb;
    else if (take)     pix_c = din;
  end

  // State, counters, shadow window and the registered raster outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      h_cnt       <= '0;
      v_cnt       <= '0;
      wx_sh       <= '0;
      wy_sh       <= '0;
      ww_sh       <= '0;
      wh_sh       <= '0;
      hs_o        <= 1'b0;
      vs_o        <= 1'b0;
      de_o        <= 1'b0;
      frame_start <= 1'b0;
      rgb_o       <= '0;
      underflow_o <= 1'b0;
    end else begin
      state <= state_nx;
      if (!live) begin
        h_cnt <= '0;
        v_cnt <= '0;
      end else if (h_cnt == HW'(H_TOTAL - 1)) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
      if (origin) begin
        wx_sh <= win_x;
        wy_sh <= win_y;
        ww_sh <= win_w;
        wh_sh <= win_h;
      end
      hs_o        <= live && hs_c;
      vs_o        <= live && vs_c;
      de_o        <= live && de_c;
      frame_start <= live && origin;
      rgb_o       <= (live && de_c) ? pix_c : '0;
      if (starve) underflow_o <= 1'b1;
    end
  end

endmodule
